// File: rtl/mvdm_pkg.sv
// Shared widths, result-word layout and FSM encoding for the MVDM SAD output serializer.
package mvdm_pkg;
  localparam int PT_W          = 4;
  localparam int SAD_W         = 24;
  localparam int RES_W         = PT_W + SAD_W;
  localparam int RES_PER_FRAME = 2;
  localparam int FIFO_DEPTH    = 4;
  localparam int FRAME_BITS    = RES_W * RES_PER_FRAME;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(RES_W);
  localparam int IDX_W = (RES_PER_FRAME > 1) ? $clog2(RES_PER_FRAME) : 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(RES_PER_FRAME);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(RES_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(RES_PER_FRAME - 1);

  typedef struct packed {
    logic [PT_W-1:0]  point;
    logic [SAD_W-1:0] sad;
  } res_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;
endpackage

// File: rtl/mvdm_sad_serializer_if.sv
// Result handshake from the datapath and the serial pad pair driven by the serializer.
interface mvdm_sad_serializer_if;
  import mvdm_pkg::*;

  logic res_valid;
  res_t res_data;
  logic res_ready;
  logic out_valid;
  logic out_sad;
  logic busy;
  logic frame_done;

  modport master (
    output res_valid, res_data,
    input  res_ready, out_valid, out_sad, busy, frame_done
  );

  modport slave (
    input  res_valid, res_data,
    output res_ready, out_valid, out_sad, busy, frame_done
  );
endinterface

// File: rtl/mvdm_res_fifo.sv
// Small synchronous result buffer with a clear that drops everything held.
module mvdm_res_fifo
  import mvdm_pkg::*;
(
  input  logic             clk,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [RES_W-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [RES_W-1:0] rd_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [RES_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o    = (count_q == DEPTH_CNT);
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/mvdm_sad_serializer.sv
// Buffers parallel SAD results and ships them MSB-first on the out_valid/out_sad pads,
// RES_PER_FRAME words per gap-free frame.
module mvdm_sad_serializer
  import mvdm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  mvdm_sad_serializer_if.slave  bus
);
  // state | meaning
  // IDLE  | pads quiet; waits until a whole frame of results is buffered
  // SEND  | shifting a frame out, words loaded back-to-back from the FIFO

  logic             fifo_clear, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [RES_W-1:0] fifo_rd_data;
  logic [CNT_W-1:0] fifo_count;

  state_e           state_q;
  logic [RES_W-2:0] sh_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [IDX_W-1:0] res_idx_q;
  logic             out_valid_q, out_sad_q, frame_done_q;

  logic             start, word_end, last_word;

  assign fifo_clear    = rst | flush;
  assign bus.res_ready = !fifo_full && !rst && !flush;
  assign fifo_push     = bus.res_valid && bus.res_ready;

  assign start     = (state_q == IDLE) && (fifo_count >= FRAME_CNT) && !flush;
  assign word_end  = (state_q == SEND) && (bit_cnt_q == BIT_LAST);
  assign last_word = (res_idx_q == IDX_LAST);
  assign fifo_pop  = !fifo_clear && !fifo_empty && (start || (word_end && !last_word));

  mvdm_res_fifo u_fifo (
    .clk       (clk),
    .clear_i   (fifo_clear),
    .push_i    (fifo_push),
    .wr_data_i (bus.res_data),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd_data),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // The word MSB goes straight to out_sad_q, so the shifter only keeps the remaining bits.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      res_idx_q    <= '0;
      out_valid_q  <= 1'b0;
      out_sad_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= SEND;
            sh_q        <= fifo_rd_data[RES_W-2:0];
            out_sad_q   <= fifo_rd_data[RES_W-1];
            out_valid_q <= 1'b1;
            bit_cnt_q   <= '0;
            res_idx_q   <= '0;
          end
        end
        SEND: begin
          if (bit_cnt_q != BIT_LAST) begin
            sh_q      <= {sh_q[RES_W-3:0], 1'b0};
            out_sad_q <= sh_q[RES_W-2];
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end else if (!last_word) begin
            sh_q      <= fifo_rd_data[RES_W-2:0];
            out_sad_q <= fifo_rd_data[RES_W-1];
            bit_cnt_q <= '0;
            res_idx_q <= res_idx_q + 1'b1;
          end else begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_sad_q    <= 1'b0;
            frame_done_q <= 1'b1;
            bit_cnt_q    <= '0;
            res_idx_q    <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_sad    = out_sad_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q == SEND);
endmodule
